dtcm_arbiter: RTL and testbench
===============================

# dtcm_arbiter

Two-port arbiter that shares the single-ported data TCM between the core load/store unit (port C) and the DMA/debug port (port D). It grants one access per cycle with round-robin fairness and drives the TCM address, write data, write-enable and byte-enable. It tracks in-flight reads through the TCM's fixed read latency, routes each read response back to its requester, and rejects misaligned or out-of-range accesses with an error response. It sits between the two requesters and the data TCM.

## Interface
- DATA_WIDTH, 32, data bus width; byte enables = DATA_WIDTH/8
- ADDR_WIDTH, 32, byte address width
- TCM_BYTES, 1024, TCM size in bytes (power of two)
- READ_LATENCY, 2, cycles from grant to valid TCM read data (1..4)
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, asynchronous, active-high
- c_req_i / d_req_i  input  1  access request, held until granted
- c_we_i / d_we_i  input  1  1 = write, 0 = read
- c_addr_i / d_addr_i  input  ADDR_WIDTH  byte address, word aligned
- c_wdata_i / d_wdata_i  input  DATA_WIDTH  write data
- c_be_i / d_be_i  input  4  byte enables
- c_gnt_o / d_gnt_o  output  1  request accepted this cycle (combinational)
- c_rvalid_o / d_rvalid_o  output  1  read response valid
- c_rdata_o / d_rdata_o  output  DATA_WIDTH  read data; 0 when rvalid is low or on error
- c_err_o / d_err_o  output  1  qualifies rvalid; access was misaligned or out of range
- tcm_addr_o  output  ADDR_WIDTH  TCM byte address
- tcm_wdata_o  output  DATA_WIDTH  TCM write data
- tcm_we_o  output  1  TCM write enable
- tcm_be_o  output  4  TCM byte enables
- tcm_rdata_i  input  DATA_WIDTH  TCM read data

## Operation
- **Arbitration:** one grant per cycle, combinational from the req inputs and the `last` pointer.
  - Only one port requesting: that port is granted.
  - Both requesting: the port that is not `last` wins.
  - `last` updates to the granted port on every grant. It resets to D, so C wins the first tie.
- **Forwarding:** a granted valid access drives tcm_addr/wdata/be from the winner, and tcm_we = winner's we.
- **Idle:** with no grant, or an invalid access, tcm_we_o = 0, tcm_be_o = 0, tcm_addr_o = 0, tcm_wdata_o = 0.
- **Invalid access:** addr[1:0] != 0, or addr >= TCM_BYTES.
  - The access is granted but never forwarded to the TCM.
  - Reads and writes both produce an error response: rvalid = 1, err = 1, rdata = 0.
- **Valid writes:** produce no response.
- **Valid reads:** produce exactly one response, rvalid = 1, err = 0, rdata = tcm_rdata_i.
- **Response pipeline:** a READ_LATENCY-deep shift register of {valid, port, err}, entered on each granted read or invalid access.
  - Responses appear strictly in grant order.
  - A response is never dropped and never needs back-pressure.
- Requester inputs may change in the grant cycle only after gnt_o. A request held without grant must remain stable.

## Timing
- Grant: same cycle as req (zero-latency acceptance when uncontested).
- Read response: rvalid asserted exactly READ_LATENCY cycles after the grant cycle; one-cycle pulse per read.
- Error response: same READ_LATENCY as a valid read, so ordering is preserved.
- Throughput: one access per cycle total. Back-to-back reads from alternating ports are fully pipelined.
- **Reset values:** all gnt, rvalid, err, rdata, and tcm_* outputs 0; pipeline cleared; `last` = D.
- **Reset mid-operation:** in-flight reads are discarded with no response. A pending TCM write in the grant cycle of reset is not issued (rst forces tcm_we_o = 0).
- **Simultaneous events:** a response delivered and a new grant in the same cycle is legal. Both ports can receive responses only in different cycles.
- **Write-then-read to the same address:** the read observes the written data when granted at least one cycle after the write.

## Test plan
- **Reset and solo read:** reset, then C reads 0x10 after the TCM model holds 0xDEADBEEF. Expect c_gnt_o in cycle 0, c_rvalid_o = 1 and c_rdata_o = 0xDEADBEEF in cycle 2, no d_* activity.
- **Contention fairness:** C and D both request reads continuously for 6 cycles. Expect grants C,D,C,D,C,D, and responses in the same order, each 2 cycles after its grant.
- **Byte-enabled write:** D writes 0xAABBCCDD to 0x20 with be = 4'b0101, then C reads 0x20 with prior contents 0. Expect tcm_be_o = 0101 in the write cycle and read data 0x00BB00DD.
- **Invalid accesses:**
  - C reads 0x402: no TCM activity (tcm_we/be = 0); c_rvalid_o = 1, c_err_o = 1, c_rdata_o = 0 in cycle 2.
  - D writes 0x3FE: d_rvalid_o = 1, d_err_o = 1 in cycle 2, memory unchanged.
- **Reset mid-flight:** C read granted, rst asserted the next cycle. Expect no c_rvalid_o ever for that read, and all outputs 0 during reset.
- **Mixed stream:** C write, D read, C read, D write back-to-back. Expect exactly two rvalid pulses, on D then C, at grant + 2 each.

Source files
------------

// File: rtl/dtcm_arbiter.sv
// Round-robin arbiter sharing the single-ported data TCM between the core LSU (C) and DMA/debug (D).
// Grant is combinational; read/error responses return READ_LATENCY cycles later in grant order, never back-pressured.
module dtcm_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int TCM_BYTES    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    c_req_i,
    input  logic                    c_we_i,
    input  logic [ADDR_WIDTH-1:0]   c_addr_i,
    input  logic [DATA_WIDTH-1:0]   c_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] c_be_i,
    output logic                    c_gnt_o,
    output logic                    c_rvalid_o,
    output logic [DATA_WIDTH-1:0]   c_rdata_o,
    output logic                    c_err_o,

    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    d_err_o,

    output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
    output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
    output logic                    tcm_we_o,
    output logic [DATA_WIDTH/8-1:0] tcm_be_o,
    input  logic [DATA_WIDTH-1:0]   tcm_rdata_i
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] TCM_LIMIT = ADDR_WIDTH'(TCM_BYTES);

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    typedef struct packed {
        logic  vld;
        port_e port;
        logic  err;
    } rsp_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BE_W-1:0]       be;
    } acc_t;

    port_e                   last_q, last_d;
    rsp_t [READ_LATENCY-1:0] pipe_q, pipe_d;

    logic gnt_c;
    logic gnt_d;
    logic any_gnt;
    logic acc_bad;
    logic fwd;
    acc_t c_acc;
    acc_t d_acc;
    acc_t win;
    rsp_t new_rsp;
    rsp_t rsp_out;

    assign c_acc = '{we: c_we_i, addr: c_addr_i, wdata: c_wdata_i, be: c_be_i};
    assign d_acc = '{we: d_we_i, addr: d_addr_i, wdata: d_wdata_i, be: d_be_i};

    // On a tie the port that did not win last time gets the slot.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (c_req_i && d_req_i) begin
                gnt_c = (last_q == PORT_D);
                gnt_d = (last_q == PORT_C);
            end else begin
                gnt_c = c_req_i;
                gnt_d = d_req_i;
            end
        end
    end

    assign c_gnt_o = gnt_c;
    assign d_gnt_o = gnt_d;
    assign any_gnt = gnt_c | gnt_d;
    assign win     = gnt_d ? d_acc : c_acc;

    assign acc_bad = (win.addr[1:0] != 2'b00) || (win.addr >= TCM_LIMIT);
    assign fwd     = any_gnt && !acc_bad;

    always_comb begin
        tcm_we_o    = 1'b0;
        tcm_be_o    = '0;
        tcm_addr_o  = '0;
        tcm_wdata_o = '0;
        if (fwd) begin
            tcm_we_o    = win.we;
            tcm_be_o    = win.be;
            tcm_addr_o  = win.addr;
            tcm_wdata_o = win.wdata;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_d) begin
            last_d = PORT_D;
        end else if (gnt_c) begin
            last_d = PORT_C;
        end
    end

    // Valid writes are silent; reads and rejected accesses each owe exactly one response.
    always_comb begin
        new_rsp      = '0;
        new_rsp.vld  = any_gnt && (!win.we || acc_bad);
        new_rsp.port = gnt_d ? PORT_D : PORT_C;
        new_rsp.err  = any_gnt && acc_bad;
    end

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = new_rsp;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT_D;
            pipe_q <= '0;
        end else begin
            last_q <= last_d;
            pipe_q <= pipe_d;
        end
    end

    assign rsp_out = pipe_q[READ_LATENCY-1];

    always_comb begin
        c_rvalid_o = rsp_out.vld && (rsp_out.port == PORT_C);
        d_rvalid_o = rsp_out.vld && (rsp_out.port == PORT_D);
        c_err_o    = c_rvalid_o && rsp_out.err;
        d_err_o    = d_rvalid_o && rsp_out.err;
        c_rdata_o  = (c_rvalid_o && !rsp_out.err) ? tcm_rdata_i : '0;
        d_rdata_o  = (d_rvalid_o && !rsp_out.err) ? tcm_rdata_i : '0;
    end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Directed bench for dtcm_arbiter: stimulus pushes expected responses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_dtcm_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_req_i, c_we_i, d_req_i, d_we_i;
    logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i;
    logic [3:0]  c_be_i, d_be_i;
    logic        c_gnt_o, c_rvalid_o, c_err_o, d_gnt_o, d_rvalid_o, d_err_o;
    logic [31:0] c_rdata_o, d_rdata_o;
    logic [31:0] tcm_addr_o, tcm_wdata_o, tcm_rdata_i;
    logic        tcm_we_o;
    logic [3:0]  tcm_be_o;

    always #5 clk = ~clk;

    dtcm_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TCM_BYTES(1024), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i), .c_be_i(c_be_i),
        .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o), .c_err_o(c_err_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
        .tcm_addr_o(tcm_addr_o), .tcm_wdata_o(tcm_wdata_o), .tcm_we_o(tcm_we_o),
        .tcm_be_o(tcm_be_o), .tcm_rdata_i(tcm_rdata_i)
    );

    // TCM model: 256 words, two-cycle read latency, byte-enabled writes.
    bit   [31:0] mem [256];
    logic [31:0] rd_q [2];
    always @(posedge clk) begin
        rd_q[0] <= mem[tcm_addr_o[9:2]];
        rd_q[1] <= rd_q[0];
        if (tcm_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (tcm_be_o[b]) mem[tcm_addr_o[9:2]][8*b +: 8] <= tcm_wdata_o[8*b +: 8];
            end
        end
    end
    assign tcm_rdata_i = rd_q[1];

    typedef struct packed {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } rq_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tcm_t;

    typedef struct {
        logic        port;
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    localparam rq_t  NOREQ = '0;
    localparam tcm_t TIDLE = '0;

    exp_t       sb [$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic       exp_chk = 1'b0;
    logic       done = 1'b0;
    logic [1:0] exp_gnt = 2'b00;
    tcm_t       exp_tcm = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rq_t rd(input logic [31:0] a);
        rq_t r;
        r = '0; r.req = 1'b1; r.addr = a; r.be = 4'hF;
        return r;
    endfunction

    function automatic rq_t wr(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        rq_t r;
        r = '0; r.req = 1'b1; r.we = 1'b1; r.addr = a; r.wdata = w; r.be = be;
        return r;
    endfunction

    function automatic tcm_t tw(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] w);
        tcm_t t;
        t.we = we; t.be = be; t.addr = a; t.wdata = w;
        return t;
    endfunction

    task automatic apply(input rq_t c, input rq_t d);
        c_req_i = c.req; c_we_i = c.we; c_addr_i = c.addr; c_wdata_i = c.wdata; c_be_i = c.be;
        d_req_i = d.req; d_we_i = d.we; d_addr_i = d.addr; d_wdata_i = d.wdata; d_be_i = d.be;
    endtask

    // eg is {c_gnt, d_gnt}; et is the expected TCM command for this cycle.
    task automatic step(input rq_t c, input rq_t d, input logic [1:0] eg, input tcm_t et);
        apply(c, d);
        exp_gnt = eg;
        exp_tcm = et;
        exp_chk = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic port, input logic err, input logic [31:0] data);
        exp_t e;
        e.port = port; e.err = err; e.data = data; e.due = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Monitor: owns all comparisons and the summary.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_gnt", {c_gnt_o, d_gnt_o}, 0);
                chk("rst_rsp", {c_rvalid_o, d_rvalid_o, c_err_o, d_err_o}, 0);
                chk("rst_rdata", {c_rdata_o, d_rdata_o}, 0);
                chk("rst_tcm_ctl", {tcm_we_o, tcm_be_o, tcm_addr_o}, 0);
                chk("rst_tcm_wdata", tcm_wdata_o, 0);
            end else begin
                if (exp_chk) begin
                    chk("gnt", {c_gnt_o, d_gnt_o}, exp_gnt);
                    chk("tcm_ctl", {tcm_we_o, tcm_be_o, tcm_addr_o}, {exp_tcm.we, exp_tcm.be, exp_tcm.addr});
                    chk("tcm_wdata", tcm_wdata_o, exp_tcm.wdata);
                end
                chk("idle_rdata", {(c_rvalid_o ? 33'b0 : {c_err_o, c_rdata_o}),
                                   (d_rvalid_o ? 33'b0 : {d_err_o, d_rdata_o})}, 0);
                if (c_rvalid_o || d_rvalid_o || (sb.size() > 0 && sb[0].due <= cyc)) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", {c_rvalid_o, d_rvalid_o}, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_port", {c_rvalid_o, d_rvalid_o}, e.port ? 2'b01 : 2'b10);
                        chk("rsp_cycle", cyc, e.due);
                        chk("rsp_err", e.port ? d_err_o : c_err_o, e.err);
                        chk("rsp_rdata", e.port ? d_rdata_o : c_rdata_o, e.data);
                    end
                end
            end
            if (done) begin
                chk("sb_drained", sb.size(), 0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        apply(wr(32'h10, 32'hCAFEF00D, 4'hF), rd(32'h20));
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Preload 0x10 through D; last becomes D.
        step(NOREQ, wr(32'h10, 32'hDEADBEEF, 4'hF), 2'b01, tw(1'b1, 4'hF, 32'h10, 32'hDEADBEEF));
        // Solo read from C.
        expect_rsp(1'b0, 1'b0, 32'hDEADBEEF);
        step(rd(32'h10), NOREQ, 2'b10, tw(1'b0, 4'hF, 32'h10, 32'h0));
        // Byte-enabled write from D; last becomes D so C wins the first tie below.
        step(NOREQ, wr(32'h20, 32'hAABBCCDD, 4'b0101), 2'b01, tw(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD));

        // Contention: C,D,C,D,C,D.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                expect_rsp(1'b0, 1'b0, 32'h00BB00DD);
                step(rd(32'h20), rd(32'h10), 2'b10, tw(1'b0, 4'hF, 32'h20, 32'h0));
            end else begin
                expect_rsp(1'b1, 1'b0, 32'hDEADBEEF);
                step(rd(32'h20), rd(32'h10), 2'b01, tw(1'b0, 4'hF, 32'h10, 32'h0));
            end
        end

        // Invalid accesses: misaligned, out of range; then the last valid word is untouched.
        expect_rsp(1'b0, 1'b1, 32'h0);
        step(rd(32'h402), NOREQ, 2'b10, TIDLE);
        expect_rsp(1'b1, 1'b1, 32'h0);
        step(NOREQ, wr(32'h3FE, 32'h12345678, 4'hF), 2'b01, TIDLE);
        expect_rsp(1'b1, 1'b1, 32'h0);
        step(NOREQ, rd(32'h400), 2'b01, TIDLE);
        expect_rsp(1'b0, 1'b0, 32'h0);
        step(rd(32'h3FC), NOREQ, 2'b10, tw(1'b0, 4'hF, 32'h3FC, 32'h0));

        // Mixed back-to-back stream.
        step(wr(32'h30, 32'h11223344, 4'hF), NOREQ, 2'b10, tw(1'b1, 4'hF, 32'h30, 32'h11223344));
        expect_rsp(1'b1, 1'b0, 32'h11223344);
        step(NOREQ, rd(32'h30), 2'b01, tw(1'b0, 4'hF, 32'h30, 32'h0));
        expect_rsp(1'b0, 1'b0, 32'hDEADBEEF);
        step(rd(32'h10), NOREQ, 2'b10, tw(1'b0, 4'hF, 32'h10, 32'h0));
        step(NOREQ, wr(32'h40, 32'h55667788, 4'b0011), 2'b01, tw(1'b1, 4'b0011, 32'h40, 32'h55667788));
        step(NOREQ, NOREQ, 2'b00, TIDLE);
        step(NOREQ, NOREQ, 2'b00, TIDLE);
        step(NOREQ, NOREQ, 2'b00, TIDLE);

        // Reset one cycle after a granted read: its response must never appear.
        step(rd(32'h10), NOREQ, 2'b10, tw(1'b0, 4'hF, 32'h10, 32'h0));
        apply(rd(32'h30), wr(32'h10, 32'h0BADF00D, 4'hF));
        exp_chk = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pointer is back at D, so C wins this tie.
        expect_rsp(1'b0, 1'b0, 32'h11223344);
        step(rd(32'h30), rd(32'h10), 2'b10, tw(1'b0, 4'hF, 32'h30, 32'h0));
        expect_rsp(1'b1, 1'b0, 32'hDEADBEEF);
        step(NOREQ, rd(32'h10), 2'b01, tw(1'b0, 4'hF, 32'h10, 32'h0));
        repeat (4) step(NOREQ, NOREQ, 2'b00, TIDLE);
        done = 1'b1;
    end

endmodule
